// File: rtl/timer_prescaler_mc.sv
// rtl/timer_prescaler_mc.sv - multi-channel double-buffered prescaler emitting one-cycle ticks
// Optional cnt_o readback port is built when PRESCALER_CNT_OUT_EN is defined.
module timer_prescaler_mc #(
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 16
) (
  input  logic                    clk,
  input  logic                    aresetn_i,
  input  logic [NUM_CH-1:0]       cce_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]       event_i,
  input  logic [NUM_CH-1:0]       ug_i,
  input  logic [NUM_CH*PSC_W-1:0] psc_i,
  output logic [NUM_CH-1:0]       tick_o
`ifdef PRESCALER_CNT_OUT_EN
  ,
  output logic [NUM_CH*PSC_W-1:0] cnt_o
`endif
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [PSC_W-1:0] cnt;
    logic [PSC_W-1:0] psc_sh;
    logic [PSC_W-1:0] psc_new;
    logic             tick;
    logic             cnt_ev;
    logic             wrap;

    assign psc_new = psc_i[n*PSC_W +: PSC_W];
    assign cnt_ev  = cce_i[n] & (mode_i[n] ? event_i[n] : 1'b1);
    // cnt never passes psc_sh, so the compare alone bounds the counter
    assign wrap    = cnt_ev & (cnt == psc_sh);

    always_ff @(posedge clk or negedge aresetn_i) begin
      if (!aresetn_i) begin
        cnt    <= '0;
        psc_sh <= '0;
        tick   <= 1'b0;
      end else if (!cce_i[n] || ug_i[n]) begin
        // disabled or forced update: shadow follows preload, any pending wrap is dropped
        cnt    <= '0;
        psc_sh <= psc_new;
        tick   <= 1'b0;
      end else if (wrap) begin
        cnt    <= '0;
        psc_sh <= psc_new;
        tick   <= 1'b1;
      end else begin
        if (cnt_ev) cnt <= cnt + PSC_W'(1);
        tick <= 1'b0;
      end
    end

    assign tick_o[n] = tick;
`ifdef PRESCALER_CNT_OUT_EN
    assign cnt_o[n*PSC_W +: PSC_W] = cnt;
`endif
  end

endmodule

// File: tb/tb_timer_prescaler_mc.sv
// tb/tb_timer_prescaler_mc.sv - directed self-checking bench for timer_prescaler_mc
// cnt_o checks are compiled only when PRESCALER_CNT_OUT_EN is defined.
module tb_timer_prescaler_mc;
  localparam int NUM_CH = 4;
  localparam int PSC_W  = 16;

  logic                    clk = 1'b0;
  logic                    aresetn_i;
  logic [NUM_CH-1:0]       cce_i;
  logic [NUM_CH-1:0]       mode_i;
  logic [NUM_CH-1:0]       event_i;
  logic [NUM_CH-1:0]       ug_i;
  logic [NUM_CH*PSC_W-1:0] psc_i;
  logic [NUM_CH-1:0]       tick_o;
`ifdef PRESCALER_CNT_OUT_EN
  logic [NUM_CH*PSC_W-1:0] cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  timer_prescaler_mc #(.NUM_CH(NUM_CH), .PSC_W(PSC_W)) dut (
    .clk       (clk),
    .aresetn_i (aresetn_i),
    .cce_i     (cce_i),
    .mode_i    (mode_i),
    .event_i   (event_i),
    .ug_i      (ug_i),
    .psc_i     (psc_i),
    .tick_o    (tick_o)
`ifdef PRESCALER_CNT_OUT_EN
    ,
    .cnt_o     (cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_psc(input int ch, input logic [PSC_W-1:0] val);
    psc_i[ch*PSC_W +: PSC_W] = val;
  endtask

  task automatic check_cnt(input string tag, input int ch, input logic [31:0] exp);
`ifdef PRESCALER_CNT_OUT_EN
    check(tag, 32'(cnt_o[ch*PSC_W +: PSC_W]), exp);
`endif
  endtask

  logic [23:0] ev_pat;
  int exp_cnt3 [1:26];
  int nev;
  int nticks;
  int cyc;

  initial begin
    aresetn_i = 1'b0;
    cce_i     = '0;
    mode_i    = '0;
    event_i   = '0;
    ug_i      = '0;
    psc_i     = '0;
    #3;
    check("reset_tick", 32'(tick_o), 32'h0);
    for (int c = 0; c < NUM_CH; c++) check_cnt("reset_cnt", c, 0);
    repeat (2) @(posedge clk);
    #1 aresetn_i = 1'b1;

    // T1/T2: ch0 divide-by-1, ch1 divide-by-4 then 8 after mid-period write, ch3 divide-by-6
    set_psc(0, 16'd0);
    set_psc(1, 16'd3);
    set_psc(3, 16'd5);
    step();
    cce_i = 4'b1011;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("t1_ch0_tick", 32'(tick_o[0]), 32'h1);
      check("t2_ch1_tick", 32'(tick_o[1]), 32'((k == 4) || (k == 8) || (k == 16) || (k == 24)));
      check("t2_ch3_tick", 32'(tick_o[3]), 32'(k % 6 == 0));
      check("t2_ch2_idle", 32'(tick_o[2]), 32'h0);
      check_cnt("t2_ch1_cnt", 1, (k < 8) ? (k % 4) : ((k - 8) % 8));
      check_cnt("t2_ch3_cnt", 3, k % 6);
      if (k == 5) set_psc(1, 16'd7);
    end

    // T3: ch2 counts event strobes, psc=2 -> tick after every 3rd strobe
    cce_i = '0;
    step();
    set_psc(2, 16'd2);
    mode_i = 4'b0100;
    step();
    cce_i  = 4'b0101;
    ev_pat = 24'b1011_0010_0110_0001_0100_1000;
    nev    = 0;
    nticks = 0;
    for (int k = 1; k <= 24; k++) begin
      event_i[2] = ev_pat[k-1];
      step();
      if (ev_pat[k-1]) nev++;
      check("t3_ch2_tick", 32'(tick_o[2]), 32'(ev_pat[k-1] && (nev % 3 == 0)));
      check("t3_ch0_tick", 32'(tick_o[0]), 32'h1);
      if (tick_o[2]) nticks++;
    end
    event_i = '0;
    check("t3_tick_total", 32'(nticks), 32'd3);

    // T4: ug_i on the wrap cycle suppresses the tick; disable at cnt=3 then re-enable with psc=1
    cce_i  = '0;
    mode_i = '0;
    set_psc(3, 16'd5);
    step();
    cce_i = 4'b1000;
    exp_cnt3 = '{1,2,3,4,5,0,1,2,3,4,5,0,1,2,3,4,5,0,1,2,3,0,1,0,1,0};
    for (int k = 1; k <= 26; k++) begin
      step();
      check("t4_ch3_tick", 32'(tick_o[3]), 32'((k == 6) || (k == 18) || (k == 24) || (k == 26)));
      check_cnt("t4_ch3_cnt", 3, exp_cnt3[k]);
      if (k == 11) ug_i[3] = 1'b1;
      if (k == 12) ug_i[3] = 1'b0;
      if (k == 21) begin
        cce_i[3] = 1'b0;
        set_psc(3, 16'd1);
      end
      if (k == 22) cce_i[3] = 1'b1;
    end

    // T5: async reset mid-count, then full-range divide
    cce_i = '0;
    set_psc(0, 16'd0);
    set_psc(1, 16'd3);
    set_psc(2, 16'd2);
    set_psc(3, 16'd5);
    step();
    cce_i = 4'b1111;
    repeat (3) step();
    check("t5_pre_reset_ch0", 32'(tick_o[0]), 32'h1);
    check_cnt("t5_pre_reset_cnt3", 3, 3);
    aresetn_i = 1'b0;
    #1;
    check("t5_reset_tick", 32'(tick_o), 32'h0);
    for (int c = 0; c < NUM_CH; c++) check_cnt("t5_reset_cnt", c, 0);
    cce_i = '0;
    step();
    aresetn_i = 1'b1;
    set_psc(1, 16'hFFFF);
    step();
    cce_i = 4'b0010;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!tick_o[1] && cyc < 70000);
    check("t5_full_range_period", 32'(cyc), 32'd65536);
    step();
    check("t5_tick_single", 32'(tick_o[1]), 32'h0);
    check_cnt("t5_cnt_after_wrap", 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
